// File: rtl/shader_fade_ctrl.sv
// Brightness sequencer for the pixel shader's 4-bit bright input.
// Holds, fades up, fades down or pulses the level at a prescaled step rate
// and emits a one-cycle done pulse when a sequence completes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command; hold and degenerate commands finish here
// UP     | ramping bright up toward the latched target
// DOWN   | ramping bright down toward the latched target
// P_UP   | pulse rising half, ramps up to the latched peak
// P_DOWN | pulse falling half, ramps down to zero then repeats or ends
module shader_fade_ctrl #(
    parameter int TICK_DIV = 25_000_000,
    parameter int STEP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] mode,
    input  logic [3:0] target,
    input  logic [3:0] cycles,
    output logic [3:0] bright,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UP     = 3'd1,
        DOWN   = 3'd2,
        P_UP   = 3'd3,
        P_DOWN = 3'd4
    } state_t;

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [4:0]      STEP5     = 5'(STEP);

    state_t        state;
    logic [PW-1:0] presc;
    logic [3:0]    tgt;
    logic [3:0]    cycles_q;
    logic [3:0]    pulse_cnt;

    logic          tick;
    logic [4:0]    sum5;
    logic [4:0]    diff5;
    logic [3:0]    up_lv;
    logic [3:0]    floor_lv;
    logic [3:0]    dn_lv;

    // Next-level arithmetic, done one bit wider so the clamps can see overflow/borrow.
    always_comb begin
        tick     = (presc == PRESC_MAX);
        sum5     = {1'b0, bright} + STEP5;
        diff5    = {1'b0, bright} - STEP5;
        up_lv    = (sum5 > {1'b0, tgt}) ? tgt : sum5[3:0];
        floor_lv = diff5[4] ? 4'd0 : diff5[3:0];
        dn_lv    = (floor_lv > tgt) ? floor_lv : tgt;
    end

    // Sequencer FSM with prescaler, pulse counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            tgt       <= 4'd0;
            cycles_q  <= 4'd0;
            pulse_cnt <= 4'd0;
            bright    <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                presc <= '0;
                if (start && !abort) begin
                    tgt      <= target;
                    cycles_q <= cycles;
                    case (mode)
                        2'b00: begin
                            bright <= target;
                            done   <= 1'b1;
                        end
                        2'b01: begin
                            if (target <= bright) begin
                                done <= 1'b1;
                            end else begin
                                state <= UP;
                                busy  <= 1'b1;
                            end
                        end
                        2'b10: begin
                            if (target >= bright) begin
                                done <= 1'b1;
                            end else begin
                                state <= DOWN;
                                busy  <= 1'b1;
                            end
                        end
                        default: begin
                            if (target == 4'd0) begin
                                done <= 1'b1;
                            end else begin
                                pulse_cnt <= cycles;
                                state     <= P_UP;
                                busy      <= 1'b1;
                            end
                        end
                    endcase
                end
            end else if (abort) begin
                // bright deliberately left frozen at its current level
                state     <= IDLE;
                busy      <= 1'b0;
                presc     <= '0;
                pulse_cnt <= 4'd0;
            end else if (!tick) begin
                presc <= presc + 1'b1;
            end else begin
                presc <= '0;
                case (state)
                    UP: begin
                        bright <= up_lv;
                        if (up_lv == tgt) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    DOWN: begin
                        bright <= dn_lv;
                        if (dn_lv == tgt) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    P_UP: begin
                        bright <= up_lv;
                        if (up_lv == tgt) begin
                            state <= P_DOWN;
                        end
                    end
                    P_DOWN: begin
                        bright <= floor_lv;
                        if (floor_lv == 4'd0) begin
                            if (cycles_q == 4'd0) begin
                                state <= P_UP;
                            end else if (pulse_cnt == 4'd1) begin
                                pulse_cnt <= 4'd0;
                                state     <= IDLE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                pulse_cnt <= pulse_cnt - 4'd1;
                                state     <= P_UP;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shader_fade_ctrl.sv
// Bench for shader_fade_ctrl: three instances with different TICK_DIV/STEP,
// each compared every cycle against a queue-of-levels reference model.
module tb_shader_fade_ctrl;

    localparam int NI = 3;
    localparam int LMAX = 512;
    localparam int TDV [NI] = '{4, 1, 1};
    localparam int STV [NI] = '{1, 4, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst    [NI];
    logic       start  [NI];
    logic       abort  [NI];
    logic [1:0] mode   [NI];
    logic [3:0] target [NI];
    logic [3:0] cycles [NI];
    logic [3:0] bright [NI];
    logic       busy   [NI];
    logic       done   [NI];

    shader_fade_ctrl #(.TICK_DIV(4), .STEP(1)) u_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]), .mode(mode[0]),
        .target(target[0]), .cycles(cycles[0]), .bright(bright[0]), .busy(busy[0]), .done(done[0]));
    shader_fade_ctrl #(.TICK_DIV(1), .STEP(4)) u_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]), .mode(mode[1]),
        .target(target[1]), .cycles(cycles[1]), .bright(bright[1]), .busy(busy[1]), .done(done[1]));
    shader_fade_ctrl #(.TICK_DIV(1), .STEP(1)) u_c (
        .clk(clk), .rst(rst[2]), .start(start[2]), .abort(abort[2]), .mode(mode[2]),
        .target(target[2]), .cycles(cycles[2]), .bright(bright[2]), .busy(busy[2]), .done(done[2]));

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: pending list of levels, one popped every TICK_DIV cycles
    int m_bright [NI];
    int m_busy   [NI];
    int m_done   [NI];
    int m_cnt    [NI];
    int m_inf    [NI];
    int m_tgt    [NI];
    int lv       [NI][LMAX];
    int len      [NI];
    int idx      [NI];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int i, input int v);
        if (len[i] < LMAX) begin
            lv[i][len[i]] = v;
            len[i]++;
        end
    endtask

    task automatic add_pulse(input int i, input int from, input int t);
        int b;
        b = from;
        do begin
            b = (b + STV[i] < t) ? b + STV[i] : t;
            push(i, b);
        end while (b != t);
        do begin
            b = (b >= STV[i]) ? b - STV[i] : 0;
            push(i, b);
        end while (b != 0);
    endtask

    task automatic model_step(input int i);
        int b;
        int t;
        int reps;
        m_done[i] = 0;
        if (rst[i]) begin
            m_bright[i] = 0; m_busy[i] = 0; m_inf[i] = 0; len[i] = 0; idx[i] = 0;
        end else if (m_busy[i] != 0) begin
            if (abort[i]) begin
                m_busy[i] = 0; len[i] = 0; idx[i] = 0;
            end else begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_cnt[i] = TDV[i];
                    m_bright[i] = lv[i][idx[i]];
                    idx[i]++;
                    if (idx[i] == len[i]) begin
                        len[i] = 0; idx[i] = 0;
                        if (m_inf[i] != 0) begin
                            add_pulse(i, 0, m_tgt[i]);
                        end else begin
                            m_busy[i] = 0; m_done[i] = 1;
                        end
                    end
                end
            end
        end else if (start[i] && !abort[i]) begin
            len[i] = 0; idx[i] = 0; m_inf[i] = 0;
            t = int'(target[i]);
            b = m_bright[i];
            m_tgt[i] = t;
            case (mode[i])
                2'd0: m_bright[i] = t;
                2'd1: while (b < t) begin
                    b = (b + STV[i] < t) ? b + STV[i] : t;
                    push(i, b);
                end
                2'd2: while (b > t) begin
                    b = (b - STV[i] > t) ? b - STV[i] : t;
                    push(i, b);
                end
                default: if (t != 0) begin
                    m_inf[i] = (cycles[i] == 4'd0) ? 1 : 0;
                    reps = (m_inf[i] != 0) ? 1 : int'(cycles[i]);
                    for (int r = 0; r < reps; r++) add_pulse(i, (r == 0) ? b : 0, t);
                end
            endcase
            if (mode[i] == 2'd0 || len[i] == 0) begin
                m_done[i] = 1;
            end else begin
                m_busy[i] = 1;
                m_cnt[i] = TDV[i];
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_step(i);
        #1;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("bright[%0d]", i), 32'(bright[i]), 32'(m_bright[i]));
            check_val($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_busy[i]));
            check_val($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
        end
    endtask

    task automatic cmd(input int i, input int md, input int tg, input int cy);
        start[i] = 1'b1;
        mode[i] = 2'(md);
        target[i] = 4'(tg);
        cycles[i] = 4'(cy);
        cycle();
        start[i] = 1'b0;
    endtask

    task automatic run_until_done(input int i, input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            cycle();
            n++;
            if (done[i]) break;
        end
        check_val($sformatf("done_seen[%0d]", i), 32'(done[i]), 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; abort[i] = 1'b0;
            mode[i] = 2'd0; target[i] = 4'd0; cycles[i] = 4'd0;
            m_bright[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
            m_inf[i] = 0; m_tgt[i] = 0; len[i] = 0; idx[i] = 0;
        end
        cycle();
        cycle();
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        repeat (20) cycle();
        check_val("idle_bright", 32'(bright[0]), 32'd0);

        // TICK_DIV=4, STEP=1: fade 3 -> 12, done 36 edges after the start edge
        cmd(0, 0, 3, 0);
        cmd(0, 1, 12, 0);
        run_until_done(0, 100, n);
        check_val("fade_up_latency", 32'(n), 32'd36);
        check_val("fade_up_final", 32'(bright[0]), 32'd12);
        cycle();
        check_val("busy_after_done", 32'(busy[0]), 32'd0);

        // STEP=4: 0 -> 14 (4,8,12,14) then down to 1 (10,6,2,1)
        cmd(1, 1, 14, 0);
        run_until_done(1, 50, n);
        check_val("step4_up_steps", 32'(n), 32'd4);
        cmd(1, 2, 1, 0);
        run_until_done(1, 50, n);
        check_val("step4_down_steps", 32'(n), 32'd4);
        check_val("step4_down_final", 32'(bright[1]), 32'd1);

        // pulse target 3, two cycles: twelve steps ending at 0
        cmd(2, 3, 3, 2);
        run_until_done(2, 50, n);
        check_val("pulse2_steps", 32'(n), 32'd12);
        check_val("pulse2_final", 32'(bright[2]), 32'd0);

        // endless pulse, ignored start while busy, abort at level 2
        cmd(2, 3, 3, 0);
        start[2] = 1'b1; mode[2] = 2'd0; target[2] = 4'd9;
        cycle();
        start[2] = 1'b0;
        n = 0;
        while (bright[2] != 4'd2 && n < 50) begin
            cycle();
            n++;
        end
        check_val("pulse_reach2", 32'(bright[2]), 32'd2);
        abort[2] = 1'b1;
        cycle();
        abort[2] = 1'b0;
        check_val("abort_hold", 32'(bright[2]), 32'd2);
        check_val("abort_busy", 32'(busy[2]), 32'd0);
        repeat (3) cycle();
        start[2] = 1'b1; abort[2] = 1'b1; mode[2] = 2'd1; target[2] = 4'd10;
        cycle();
        start[2] = 1'b0; abort[2] = 1'b0;
        check_val("start_abort_busy", 32'(busy[2]), 32'd0);
        cycle();
        check_val("start_abort_busy2", 32'(busy[2]), 32'd0);

        // corner cases on TICK_DIV=4 instance
        cmd(0, 0, 9, 0);
        check_val("hold_bright", 32'(bright[0]), 32'd9);
        check_val("hold_done", 32'(done[0]), 32'd1);
        check_val("hold_busy", 32'(busy[0]), 32'd0);
        cmd(0, 2, 12, 0);
        check_val("degen_down_done", 32'(done[0]), 32'd1);
        check_val("degen_down_bright", 32'(bright[0]), 32'd9);
        cmd(0, 3, 0, 3);
        check_val("degen_pulse_done", 32'(done[0]), 32'd1);
        cmd(0, 2, 0, 0);
        repeat (10) cycle();
        rst[0] = 1'b1;
        cycle();
        rst[0] = 1'b0;
        check_val("rst_mid_bright", 32'(bright[0]), 32'd0);
        check_val("rst_mid_busy", 32'(busy[0]), 32'd0);

        // randomized traffic on all instances
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                rst[i]    = ($urandom_range(0, 299) == 0);
                abort[i]  = ($urandom_range(0, 39) == 0);
                start[i]  = ($urandom_range(0, 5) == 0);
                mode[i]   = 2'($urandom_range(0, 3));
                target[i] = 4'($urandom_range(0, 15));
                cycles[i] = 4'($urandom_range(0, 3));
            end
            cycle();
        end
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0; start[i] = 1'b0; abort[i] = 1'b0;
        end
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
